// File: rtl/ocp_burst_slave_if.sv
// OCP 2.2 burst command/data/response bundle between axi2ocp (master) and
// a burst slave target.
interface ocp_burst_slave_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
);
  logic              enable;
  logic [ADDR_W-1:0] address;
  logic [2:0]        burst_seq;
  logic              burst_single_req;
  logic [9:0]        burst_length;
  logic              read_request;
  logic              write_request;
  logic              writeresp_enable;
  logic              data_valid;
  logic [DATA_W-1:0] write_data;
  logic              cmd_accept;
  logic              data_accept;
  logic [1:0]        resp;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_last;
  logic              resp_accept;

  modport master (
    output enable, address, burst_seq, burst_single_req, burst_length,
           read_request, write_request, writeresp_enable, data_valid,
           write_data, resp_accept,
    input  cmd_accept, data_accept, resp, resp_valid, resp_data, resp_last
  );

  modport slave (
    input  enable, address, burst_seq, burst_single_req, burst_length,
           read_request, write_request, writeresp_enable, data_valid,
           write_data, resp_accept,
    output cmd_accept, data_accept, resp, resp_valid, resp_data, resp_last
  );
endinterface

// File: rtl/ocp_burst_slave.sv
// OCP burst slave backed by a word-addressed register-file memory; serves
// INCR write/read bursts one at a time and answers bad commands with ERR.
module ocp_burst_slave #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ocp_reset,
  ocp_burst_slave_if.slave bus
);
  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [MEM_AW-1:0]   addr_cnt_q, addr_cnt_d;
  logic [9:0]          beat_cnt_q, beat_cnt_d;
  logic                wresp_q, wresp_d;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_q [2**MEM_AW];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.address[ADDR_W-1:MEM_AW+2], bus.address[1:0],
                              bus.burst_single_req};

  always_comb begin
    state_d         = state_q;
    addr_cnt_d      = addr_cnt_q;
    beat_cnt_d      = beat_cnt_q;
    wresp_d         = wresp_q;
    mem_we          = 1'b0;
    bus.cmd_accept  = 1'b0;
    bus.data_accept = 1'b0;
    bus.resp        = RESP_NULL;
    bus.resp_valid  = 1'b0;
    bus.resp_data   = '0;
    bus.resp_last   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        bus.cmd_accept = reset && !ocp_reset;
        if (bus.enable && (bus.read_request || bus.write_request)) begin
          addr_cnt_d = bus.address[MEM_AW+1:2];
          beat_cnt_d = bus.burst_length;
          wresp_d    = bus.writeresp_enable;
          if ((bus.read_request && bus.write_request) ||
              (bus.burst_seq != 3'b000) || (bus.burst_length == 10'd0))
            state_d = S_ERR;
          else if (bus.write_request)
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end

      S_WR: begin
        bus.data_accept = 1'b1;
        if (bus.data_valid) begin
          mem_we     = 1'b1;
          addr_cnt_d = addr_cnt_q + MEM_AW'(1);
          beat_cnt_d = beat_cnt_q - 10'd1;
          if (beat_cnt_q == 10'd1)
            state_d = wresp_q ? S_WR_RESP : S_IDLE;
        end
      end

      S_WR_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp       = RESP_DVA;
        bus.resp_last  = 1'b1;
        if (bus.resp_accept)
          state_d = S_IDLE;
      end

      S_RD: begin
        bus.resp_valid = 1'b1;
        bus.resp       = RESP_DVA;
        bus.resp_data  = mem_q[addr_cnt_q];
        bus.resp_last  = (beat_cnt_q == 10'd1);
        if (bus.resp_accept) begin
          addr_cnt_d = addr_cnt_q + MEM_AW'(1);
          beat_cnt_d = beat_cnt_q - 10'd1;
          if (beat_cnt_q == 10'd1)
            state_d = S_IDLE;
        end
      end

      S_ERR: begin
        bus.resp_valid = 1'b1;
        bus.resp       = RESP_ERR;
        bus.resp_last  = 1'b1;
        if (bus.resp_accept)
          state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Soft reset wins over everything, including a write beat this cycle.
    if (ocp_reset) begin
      state_d    = S_IDLE;
      addr_cnt_d = '0;
      beat_cnt_d = '0;
      wresp_d    = 1'b0;
      mem_we     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_cnt_q <= '0;
      beat_cnt_q <= '0;
      wresp_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      wresp_q    <= wresp_d;
    end
  end

  // Memory contents survive both resets.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[addr_cnt_q] <= bus.write_data;
  end
endmodule
